// File: rtl/smc_dtheta_est_pkg.sv
// Shared arithmetic/control constants for the SMC dtheta estimator.
// Contents: Q16.16 width, default control-tick divider, saturation limits,
// FSM state encoding and the 48-bit -> Q16.16 clamp helper.
package smc_dtheta_est_pkg;

  localparam int unsigned Q_W           = 32;
  localparam int unsigned MUL_W         = 48;
  localparam int unsigned CTRL_TICK_DIV = 5000;

  localparam logic [Q_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SCALE  = 3'd2,
    ST_FILT   = 3'd3,
    ST_STROBE = 3'd4
  } state_e;

  // Clamp a signed 48-bit value into signed Q16.16. Bit 32 of the result is
  // the overflow flag; bits 31:0 are the clamped value. The value fits only
  // when bits 47:31 are all equal.
  function automatic logic [Q_W:0] sat_to_q(input logic [MUL_W-1:0] v);
    logic [Q_W:0] r;
    if (!v[MUL_W-1] && (|v[MUL_W-2:Q_W-1])) begin
      r = {1'b1, SAT_MAX};
    end else if (v[MUL_W-1] && !(&v[MUL_W-2:Q_W-1])) begin
      r = {1'b1, SAT_MIN};
    end else begin
      r = {1'b0, v[Q_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/smc_dtheta_est_sat_round_shift.sv
// sat_round_shift: y = sat32(((a * b) >>> SHIFT) + c), 48-bit intermediate.
// Ports:
//   a_i  [A_W-1:0] signed multiplicand
//   b_i  [31:0]    unsigned multiplier (Q0.16 gain, or 1 for a pure shift)
//   c_i  [31:0]    signed addend applied after the shift
//   y_o  [31:0]    saturated signed result
//   ov_o           high when the result was clamped
module sat_round_shift
  import smc_dtheta_est_pkg::*;
#(
  parameter int unsigned A_W   = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic [A_W-1:0] a_i,
  input  logic [Q_W-1:0] b_i,
  input  logic [Q_W-1:0] c_i,
  output logic [Q_W-1:0] y_o,
  output logic           ov_o
);

  logic signed [MUL_W-1:0] a_ext_s;
  logic signed [MUL_W-1:0] b_ext_s;
  logic signed [MUL_W-1:0] prod_s;
  logic signed [MUL_W-1:0] shr_s;
  logic signed [MUL_W-1:0] sum_s;
  logic        [Q_W:0]     res_s;

  // Sign-extend a, zero-extend b, multiply, arithmetic-shift, add, clamp.
  always_comb begin
    a_ext_s = {{(MUL_W-A_W){a_i[A_W-1]}}, a_i};
    b_ext_s = {{(MUL_W-Q_W){1'b0}}, b_i};
    prod_s  = a_ext_s * b_ext_s;
    shr_s   = prod_s >>> SHIFT;
    sum_s   = shr_s + {{(MUL_W-Q_W){c_i[Q_W-1]}}, c_i};
    res_s   = sat_to_q(sum_s);
    y_o     = res_s[Q_W-1:0];
    ov_o    = res_s[Q_W];
  end

endmodule

// File: rtl/smc_dtheta_est.sv
// smc_dtheta_est: control-tick generator, encoder finite-difference velocity,
// first-order IIR filter and start/done strobe sequencer feeding the SMC
// disturbance observer.
// Ports:
//   clk_i          system clock
//   rst_n          asynchronous active-low reset
//   stop_rst_i     synchronous clear (shared with the observer)
//   enable_i       run control ticks while high
//   enc_pos_i      raw encoder count, wraps modulo 2^ENC_W
//   dtheta_o       filtered velocity, signed Q16.16
//   start_o        observer input-latch strobe
//   done_o         observer state-latch strobe
//   busy_o         sequence in progress
//   sat_o          sticky saturation flag
module smc_dtheta_est
  import smc_dtheta_est_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CTRL_TICK_DIV,
  parameter int unsigned ENC_W       = 16,
  parameter logic [31:0] VEL_GAIN    = 32'd4096,
  parameter int unsigned VEL_SHIFT   = 4,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned STROBE_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             stop_rst_i,
  input  logic             enable_i,
  input  logic [ENC_W-1:0] enc_pos_i,
  output logic [Q_W-1:0]   dtheta_o,
  output logic             start_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             sat_o
);

  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned SEQ_LEN = SETTLE + STROBE_W;
  localparam int unsigned SC_W    = $clog2(SEQ_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SEQ_LEN - 1);
  localparam logic [SC_W-1:0]  START_END = SC_W'(STROBE_W);
  localparam logic [SC_W-1:0]  DONE_BEG  = SC_W'(SETTLE);
  localparam logic [SC_W-1:0]  DONE_END  = SC_W'(SEQ_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [ENC_W-1:0] pos_prev_q, pos_prev_d;
  logic [ENC_W-1:0] delta_q, delta_d;
  logic             first_q, first_d;
  logic [Q_W-1:0]   vraw_q, vraw_d;
  logic [Q_W-1:0]   y_q, y_d;
  logic             sat_q, sat_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             tick_s;
  logic [Q_W-1:0]   scale_y_s;
  logic             scale_ov_s;
  logic [Q_W:0]     diff_s;
  logic [Q_W-1:0]   filt_y_s;
  logic             filt_ov_s;

  // delta is an ENC_W-bit modular difference; sign extension inside the
  // multiplier turns the 0xFFFF -> 0x0000 wrap into +1.
  sat_round_shift #(
    .A_W   (ENC_W),
    .SHIFT (VEL_SHIFT)
  ) u_scale (
    .a_i  (delta_q),
    .b_i  (VEL_GAIN),
    .c_i  (32'd0),
    .y_o  (scale_y_s),
    .ov_o (scale_ov_s)
  );

  // IIR: y + ((v_raw - y) >>> ALPHA_SHIFT), difference kept in 33 bits.
  sat_round_shift #(
    .A_W   (Q_W + 1),
    .SHIFT (ALPHA_SHIFT)
  ) u_filt (
    .a_i  (diff_s),
    .b_i  (32'd1),
    .c_i  (y_q),
    .y_o  (filt_y_s),
    .ov_o (filt_ov_s)
  );

  // Control-tick counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    diff_s = {vraw_q[Q_W-1], vraw_q} - {y_q[Q_W-1], y_q};
    tick_s = enable_i && (cnt_q == CNT_LAST);
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic; ticks outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: state_d = ST_SCALE;
      ST_SCALE:  state_d = ST_FILT;
      ST_FILT: begin
        state_d = ST_STROBE;
        sc_d    = '0;
      end
      ST_STROBE: begin
        if (sc_q == SC_LAST) begin
          state_d = ST_IDLE;
          sc_d    = '0;
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = '0;
      end
    endcase
  end

  // Datapath updates and registered strobe decode from the next state.
  always_comb begin
    pos_prev_d = pos_prev_q;
    delta_d    = delta_q;
    first_d    = first_q;
    vraw_d     = vraw_q;
    y_d        = y_q;
    sat_d      = sat_q;
    case (state_q)
      ST_SAMPLE: begin
        pos_prev_d = enc_pos_i;
        first_d    = 1'b0;
        if (first_q) begin
          delta_d = '0;
        end else begin
          delta_d = enc_pos_i - pos_prev_q;
        end
      end
      ST_SCALE: begin
        vraw_d = scale_y_s;
        sat_d  = sat_q | scale_ov_s;
      end
      ST_FILT: begin
        y_d   = filt_y_s;
        sat_d = sat_q | filt_ov_s;
      end
      default: begin
        sat_d = sat_q;
      end
    endcase
    start_d = (state_d == ST_STROBE) && (sc_d < START_END);
    done_d  = (state_d == ST_STROBE) && (sc_d >= DONE_BEG) && (sc_d < DONE_END);
    busy_d  = (state_d != ST_IDLE);
  end

  // State register; stop_rst overrides every transition, mid-sequence included.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sc_q       <= '0;
      pos_prev_q <= '0;
      delta_q    <= '0;
      first_q    <= 1'b1;
      vraw_q     <= '0;
      y_q        <= '0;
      sat_q      <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (stop_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sc_q       <= '0;
      pos_prev_q <= '0;
      delta_q    <= '0;
      first_q    <= 1'b1;
      vraw_q     <= '0;
      y_q        <= '0;
      sat_q      <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sc_q       <= sc_d;
      pos_prev_q <= pos_prev_d;
      delta_q    <= delta_d;
      first_q    <= first_d;
      vraw_q     <= vraw_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
      start_q    <= start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign dtheta_o = y_q;
  assign start_o  = start_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_smc_dtheta_est.sv
// Scoreboard bench: three estimators (bypass filter, alpha=1/4, saturating
// gain) share stimulus; a reference model pushes expected dtheta/sat per tick
// and a monitor pops and checks at every start rising edge, then follows the
// strobe sequence cycle by cycle.
module tb_smc_dtheta_est;

  localparam int unsigned C      = 64;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned SW     = 4;
  localparam int          NT     = 15;
  localparam int          ABORT_I = 12;

  logic        clk = 1'b0;
  logic        rst_n, stop_rst, enable;
  logic [15:0] enc_pos;
  logic [31:0] dth_a, dth_b, dth_c;
  logic        start_a, start_b, start_c, done_a, done_b, done_c;
  logic        busy_a, busy_b, busy_c, sat_a, sat_b, sat_c;
  logic [2:0]  start_w, done_w, busy_w, sat_w;
  logic [2:0][31:0] dth_w;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic             abort;
    logic [2:0]       sat;
    logic [2:0][31:0] dth;
  } exp_t;
  exp_t exp_q[$];

  // model configuration and state, one slot per DUT
  int     ashift [3] = '{0, 2, 0};
  int     vshift [3] = '{4, 4, 0};
  longint gain   [3] = '{64'd4096, 64'd4096, 64'hFFFF_FFFF};
  bit     first_m[3];
  int     prev_m [3];
  longint y_m    [3];
  bit     sat_m  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    start_w = {start_c, start_b, start_a};
    done_w  = {done_c, done_b, done_a};
    busy_w  = {busy_c, busy_b, busy_a};
    sat_w   = {sat_c, sat_b, sat_a};
    dth_w   = {dth_c, dth_b, dth_a};
  end

  smc_dtheta_est #(.CLK_DIV(C), .ALPHA_SHIFT(0)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .stop_rst_i(stop_rst), .enable_i(enable),
    .enc_pos_i(enc_pos), .dtheta_o(dth_a), .start_o(start_a), .done_o(done_a),
    .busy_o(busy_a), .sat_o(sat_a));

  smc_dtheta_est #(.CLK_DIV(C), .ALPHA_SHIFT(2)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .stop_rst_i(stop_rst), .enable_i(enable),
    .enc_pos_i(enc_pos), .dtheta_o(dth_b), .start_o(start_b), .done_o(done_b),
    .busy_o(busy_b), .sat_o(sat_b));

  smc_dtheta_est #(.CLK_DIV(C), .ALPHA_SHIFT(0), .VEL_GAIN(32'hFFFF_FFFF),
                   .VEL_SHIFT(0)) dut_c (
    .clk_i(clk), .rst_n(rst_n), .stop_rst_i(stop_rst), .enable_i(enable),
    .enc_pos_i(enc_pos), .dtheta_o(dth_c), .start_o(start_c), .done_o(done_c),
    .busy_o(busy_c), .sat_o(sat_c));

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 3; j++) begin
      first_m[j] = 1'b1;
      prev_m[j]  = 0;
      y_m[j]     = 0;
      sat_m[j]   = 1'b0;
    end
  endfunction

  // Velocity and filter from the arithmetic definition, then queue the result.
  function automatic void model_tick(input int pos, input bit abort);
    exp_t   e;
    int     d;
    longint v, vs, f, fs;
    for (int j = 0; j < 3; j++) begin
      if (first_m[j]) begin
        d = 0;
      end else begin
        d = (pos - prev_m[j]) & 32'h0000_FFFF;
        if (d >= 32768) d = d - 65536;
      end
      first_m[j] = 1'b0;
      prev_m[j]  = pos;
      v  = (longint'(d) * gain[j]) >>> vshift[j];
      vs = clamp(v);
      if (vs != v) sat_m[j] = 1'b1;
      f  = y_m[j] + ((vs - y_m[j]) >>> ashift[j]);
      fs = clamp(f);
      if (fs != f) sat_m[j] = 1'b1;
      y_m[j]    = fs;
      e.dth[j]  = 32'(fs);
      e.sat[j]  = sat_m[j];
    end
    e.abort = abort;
    exp_q.push_back(e);
    if (abort) model_reset();
  endfunction

  // Stimulus: one encoder value per tick, applied mid-period.
  initial begin
    int pos;
    rst_n    = 1'b0;
    stop_rst = 1'b0;
    enable   = 1'b0;
    enc_pos  = 16'h1234;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_dtheta", {dth_c, dth_b, dth_a}, 128'd0);
    chk("reset_ctl", {start_w, done_w, busy_w, sat_w}, 128'd0);
    rst_n   = 1'b1;
    enable  = 1'b1;
    rel_cyc = cyc;
    mon_en  = 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    pos = 32'h1234;
    for (int i = 0; i < NT; i++) begin
      if (i < 5)       pos = 32'h1234 + 10 * i;
      else if (i == 5) pos = 32'hFFFE;
      else if (i == 6) pos = 32'h0003;
      else if (i == 7) pos = 32'hFFFE;
      else if (i == 8) pos = (pos + 32767) & 32'hFFFF;
      else             pos = (pos + int'($urandom_range(0, 400)) - 200) & 32'hFFFF;
      enc_pos = pos[15:0];
      model_tick(pos, i == ABORT_I);
      if (i == ABORT_I) begin
        // start rises C/2+3 edges from here; stop_rst is sampled 2 edges later
        repeat (C / 2 + 4) @(posedge clk);
        #1 stop_rst = 1'b1;
        @(posedge clk);
        #1 stop_rst = 1'b0;
        repeat (C / 2 - 5) @(posedge clk);
        #1;
      end else begin
        repeat (C) @(posedge clk);
        #1;
      end
    end
    repeat (40) @(posedge clk);
    #1;
    chk("pending_expectations", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: on each start rise compare against the scoreboard, then track
  // the strobe/done/busy pattern and dtheta stability through the sequence.
  initial begin
    bit   first_seen = 1'b0;
    logic prev_start = 1'b0;
    exp_t e;
    logic es, ed, eb;
    logic [2:0] esat;
    logic [2:0][31:0] edth;
    forever begin
      @(negedge clk);
      if (mon_en && start_w[0] && !prev_start) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("first_start_latency", 128'(cyc - rel_cyc), 128'(C + 3));
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dtheta_at_start", dth_w, e.dth);
          chk("ctl_at_start", {start_w, done_w, busy_w, sat_w},
              {3'b111, 3'b000, 3'b111, e.sat});
          for (int c = 1; c <= int'(SETTLE + SW); c++) begin
            @(negedge clk);
            if (e.abort) begin
              es = (c < 2); ed = 1'b0; eb = (c < 2);
              esat = (c < 2) ? e.sat : 3'b000;
              edth = (c < 2) ? e.dth : '0;
            end else begin
              es = (c < int'(SW));
              ed = (c >= int'(SETTLE)) && (c < int'(SETTLE + SW));
              eb = (c < int'(SETTLE + SW));
              esat = e.sat;
              edth = e.dth;
            end
            chk($sformatf("%s_ctl c=%0d", e.abort ? "abort" : "strobe", c),
                {start_w, done_w, busy_w, sat_w}, {{3{es}}, {3{ed}}, {3{eb}}, esat});
            chk($sformatf("%s_dtheta c=%0d", e.abort ? "abort" : "hold", c),
                dth_w, edth);
          end
        end
      end
      prev_start = start_w[0];
    end
  end

endmodule
